// File: rtl/spi_responder_pkg.sv
// Shared types for the SPI byte responder: byte payload, FSM states, bit counter width.
package spi_responder_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  localparam int unsigned BIT_CNT_W = 3;

endpackage

// File: rtl/spi_tx_fifo.sv
// Synchronous response-byte FIFO; push is ignored when full, pop is ignored when empty.
module spi_tx_fifo
  import spi_responder_pkg::*;
#(
  parameter int unsigned  DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_push,
  input  byte_t         i_data,
  input  logic          i_pop,
  output byte_t         o_head,
  output logic [LW-1:0] o_level,
  output logic [LW-1:0] o_level_next,
  output logic          o_full,
  output logic          o_empty
);

  byte_t         r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_push;
  logic          w_pop;

  assign o_full       = (r_level == LW'(DEPTH));
  assign o_empty      = (r_level == '0);
  assign w_push       = i_push && !o_full;
  assign w_pop        = i_pop && !o_empty;
  assign o_level_next = r_level + LW'(w_push) - LW'(w_pop);
  assign o_level      = r_level;
  assign o_head       = r_mem[r_rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= o_level_next;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/spi_byte_responder.sv
// SPI mode-0 slave: oversampled pins, per-byte receive strobe and queued MISO responses.
// Define SPI_RESPONDER_OVERFLOW_EN to enable the sticky tx_overflow flag.
module spi_byte_responder
  import spi_responder_pkg::*;
#(
  parameter int unsigned  TX_DEPTH    = 4,
  parameter byte_t        IDLE_BYTE   = 8'h00,
  parameter int unsigned  SYNC_STAGES = 2,
  localparam int unsigned LVL_W       = $clog2(TX_DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             spi_sclk,
  input  logic             spi_cs_n,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output byte_t            rx_data,
  output logic             rx_valid,
  input  byte_t            tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [LVL_W-1:0] tx_level,
  output logic             dataReady,
  output logic             tx_overflow
);

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic                   r_sclk_dly, r_cs_dly, r_mosi_dly;
  state_t                 r_state;
  logic [BIT_CNT_W-1:0]   r_bit_cnt;
  logic [6:0]             r_tx_rest;
  logic [6:0]             r_rx_shift;
  logic                   r_miso, r_rx_valid, r_tx_ready, r_data_ready;
  byte_t                  r_rx_data;

  logic                   w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
  logic                   w_reload, w_push, w_fifo_full, w_fifo_empty;
  byte_t                  w_fifo_head, w_load_byte;
  logic [LVL_W-1:0]       w_level, w_level_next;

  // Pin synchronizers plus one delay stage for edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_dly  <= 1'b0;
      r_cs_dly    <= 1'b1;
      r_mosi_dly  <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_sclk_dly  <= r_sclk_sync[SYNC_STAGES-1];
      r_cs_dly    <= r_cs_sync[SYNC_STAGES-1];
      r_mosi_dly  <= r_mosi_sync[SYNC_STAGES-1];
    end
  end

  assign w_sclk_rise = r_sclk_sync[SYNC_STAGES-1] && !r_sclk_dly;
  assign w_sclk_fall = !r_sclk_sync[SYNC_STAGES-1] && r_sclk_dly;
  assign w_cs_fall   = !r_cs_sync[SYNC_STAGES-1] && r_cs_dly;
  assign w_cs_rise   = r_cs_sync[SYNC_STAGES-1] && !r_cs_dly;

  // A queue pop happens at transfer start and at every byte boundary.
  assign w_reload    = !w_cs_rise && ((r_state == LOAD) ||
                       ((r_state == SHIFT) && w_sclk_fall && (r_bit_cnt == '0)));
  assign w_load_byte = w_fifo_empty ? IDLE_BYTE : w_fifo_head;
  assign w_push      = tx_valid && r_tx_ready && !w_fifo_full;

  spi_tx_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clock        (clock),
    .reset        (reset),
    .i_push       (w_push),
    .i_data       (tx_data),
    .i_pop        (w_reload),
    .o_head       (w_fifo_head),
    .o_level      (w_level),
    .o_level_next (w_level_next),
    .o_full       (w_fifo_full),
    .o_empty      (w_fifo_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_tx_rest  <= '0;
      r_rx_shift <= '0;
      r_miso     <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_cs_rise) begin
        r_state   <= IDLE;
        r_bit_cnt <= '0;
        r_miso    <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_bit_cnt <= '0;
            r_miso    <= 1'b0;
            if (w_cs_fall) r_state <= LOAD;
          end
          LOAD: begin
            r_miso    <= w_load_byte[7];
            r_tx_rest <= w_load_byte[6:0];
            r_state   <= SHIFT;
          end
          SHIFT: begin
            if (w_sclk_rise) begin
              r_rx_shift <= {r_rx_shift[5:0], r_mosi_dly};
              r_bit_cnt  <= r_bit_cnt + BIT_CNT_W'(1);
              if (r_bit_cnt == BIT_CNT_W'(7)) begin
                r_rx_data  <= {r_rx_shift, r_mosi_dly};
                r_rx_valid <= 1'b1;
              end
            end else if (w_sclk_fall) begin
              if (r_bit_cnt != '0) begin
                r_miso    <= r_tx_rest[6];
                r_tx_rest <= {r_tx_rest[5:0], 1'b0};
              end else begin
                r_miso    <= w_load_byte[7];
                r_tx_rest <= w_load_byte[6:0];
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tx_ready   <= 1'b1;
      r_data_ready <= 1'b0;
    end else begin
      r_tx_ready   <= (w_level_next != LVL_W'(TX_DEPTH));
      r_data_ready <= (w_level != '0);
    end
  end

`ifdef SPI_RESPONDER_OVERFLOW_EN
  logic r_overflow;

  // Host command 0x00 acknowledges a dropped response byte.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (tx_valid && !r_tx_ready) begin
      r_overflow <= 1'b1;
    end else if (r_rx_valid && (r_rx_data == 8'h00)) begin
      r_overflow <= 1'b0;
    end
  end

  assign tx_overflow = r_overflow;
`else
  assign tx_overflow = 1'b0;
`endif

  assign spi_miso  = r_miso;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign tx_ready  = r_tx_ready;
  assign tx_level  = w_level;
  assign dataReady = r_data_ready;

endmodule

// File: tb/tb_spi_byte_responder.sv
// Bench for spi_byte_responder: drives a mode-0 SPI host and compares against a queue model.
module tb_spi_byte_responder;

  localparam int unsigned TX_DEPTH    = 4;
  localparam int unsigned SYNC_STAGES = 2;
  localparam logic [7:0]  IDLE_BYTE   = 8'h00;
  localparam int          PH          = 6;
`ifdef SPI_RESPONDER_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       spi_sclk, spi_cs_n, spi_mosi, spi_miso;
  logic [7:0] rx_data, tx_data;
  logic       rx_valid, tx_valid, tx_ready, dataReady, tx_overflow;
  logic [2:0] tx_level;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] m_next;
  bit         m_ovf;

  spi_byte_responder #(
    .TX_DEPTH(TX_DEPTH), .IDLE_BYTE(IDLE_BYTE), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clock(clock), .reset(reset), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_level(tx_level),
    .dataReady(dataReady), .tx_overflow(tx_overflow)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (rx_valid === 1'b1) rx_q.push_back(rx_data);

  initial begin
    #3000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] model_pop();
    if (m_q.size() == 0) return IDLE_BYTE;
    return m_q.pop_front();
  endfunction

  task automatic model_push(input logic [7:0] b);
    if (m_q.size() < TX_DEPTH) m_q.push_back(b);
    else if (OVF_EN) m_ovf = 1'b1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    logic exp_rdy;
    @(negedge clock);
    exp_rdy = (m_q.size() < TX_DEPTH);
    checks++;
    if (tx_ready !== exp_rdy) begin
      failures++;
      $display("FAIL push_ready act=%b exp=%b level=%0d", tx_ready, exp_rdy, m_q.size());
    end
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    model_push(b);
  endtask

  task automatic spi_begin();
    @(negedge clock);
    spi_cs_n = 1'b0;
    m_next   = model_pop();
    repeat (PH) @(negedge clock);
  endtask

  task automatic spi_bit(input logic mo, output logic mi);
    spi_mosi = mo;
    repeat (PH) @(negedge clock);
    mi       = spi_miso;
    spi_sclk = 1'b1;
    repeat (PH) @(negedge clock);
    spi_sclk = 1'b0;
  endtask

  // One full byte; the fall after its last bit pops the next response byte.
  task automatic spi_byte(input logic [7:0] mo, output logic [7:0] mi, output logic [7:0] ex);
    logic b;
    ex = m_next;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(mo[i], b);
      mi[i] = b;
    end
    m_next = model_pop();
    if (mo == 8'h00) m_ovf = 1'b0;
  endtask

  task automatic spi_end();
    repeat (PH) @(negedge clock);
    spi_cs_n = 1'b1;
    repeat (PH) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00; m_ovf = 1'b0;
    repeat (3) @(negedge clock);
    checks += 7;
    if (spi_miso !== 1'b0)    begin failures++; $display("FAIL rst_miso act=%b exp=0", spi_miso); end
    if (rx_data !== 8'h00)    begin failures++; $display("FAIL rst_rx_data act=%h exp=00", rx_data); end
    if (rx_valid !== 1'b0)    begin failures++; $display("FAIL rst_rx_valid act=%b exp=0", rx_valid); end
    if (tx_ready !== 1'b1)    begin failures++; $display("FAIL rst_tx_ready act=%b exp=1", tx_ready); end
    if (tx_level !== 3'd0)    begin failures++; $display("FAIL rst_tx_level act=%0d exp=0", tx_level); end
    if (dataReady !== 1'b0)   begin failures++; $display("FAIL rst_dataReady act=%b exp=0", dataReady); end
    if (tx_overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow act=%b exp=0", tx_overflow); end
    reset = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_single_byte();
    logic [7:0] mi, ex;
    rx_q.delete();
    spi_begin(); spi_byte(8'h02, mi, ex); spi_end();
    checks += 3;
    if (mi !== ex) begin failures++; $display("FAIL single_miso act=%h exp=%h", mi, ex); end
    if (rx_q.size() != 1 || rx_q[0] !== 8'h02) begin
      failures++; $display("FAIL single_rx count=%0d exp_count=1 exp=02", rx_q.size());
    end
    if (dataReady !== 1'b0) begin failures++; $display("FAIL single_dataReady act=%b exp=0", dataReady); end
  endtask

  task automatic test_string();
    logic [7:0] str [4];
    logic [7:0] mi, ex;
    str[0] = 8'h31; str[1] = 8'h41; str[2] = 8'h4C; str[3] = 8'h53;
    rx_q.delete();
    for (int k = 0; k < 4; k++) push_byte(str[k]);
    repeat (2) @(negedge clock);
    checks += 3;
    if (tx_level !== 3'd4)  begin failures++; $display("FAIL str_level act=%0d exp=4", tx_level); end
    if (dataReady !== 1'b1) begin failures++; $display("FAIL str_dataReady_hi act=%b exp=1", dataReady); end
    if (tx_ready !== 1'b0)  begin failures++; $display("FAIL str_ready_full act=%b exp=0", tx_ready); end
    spi_begin();
    for (int k = 0; k < 4; k++) begin
      spi_byte(8'h7F, mi, ex);
      checks++;
      if (mi !== ex || mi !== str[k]) begin
        failures++; $display("FAIL str_miso%0d act=%h exp=%h", k, mi, str[k]);
      end
    end
    spi_end();
    checks += 2;
    if (dataReady !== 1'b0 || tx_level !== 3'd0) begin
      failures++; $display("FAIL str_drain dataReady=%b level=%0d exp=0/0", dataReady, tx_level);
    end
    if (rx_q.size() != 4) begin
      failures++; $display("FAIL str_rx_count act=%0d exp=4", rx_q.size());
    end else begin
      foreach (rx_q[k]) begin
        checks++;
        if (rx_q[k] !== 8'h7F) begin failures++; $display("FAIL str_rx%0d act=%h exp=7f", k, rx_q[k]); end
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] mi, ex;
    for (int k = 0; k < 5; k++) push_byte(8'($urandom));
    repeat (2) @(negedge clock);
    checks += 2;
    if (tx_level !== 3'd4) begin failures++; $display("FAIL ovf_level act=%0d exp=4", tx_level); end
    if (tx_overflow !== m_ovf || m_ovf !== OVF_EN) begin
      failures++; $display("FAIL ovf_set act=%b exp=%b", tx_overflow, OVF_EN);
    end
    spi_begin();
    for (int k = 0; k < 4; k++) begin
      spi_byte((k == 0) ? 8'h00 : (8'($urandom) | 8'h01), mi, ex);
      checks++;
      if (mi !== ex) begin failures++; $display("FAIL ovf_miso%0d act=%h exp=%h", k, mi, ex); end
    end
    spi_end();
    checks++;
    if (tx_overflow !== 1'b0 || m_ovf) begin
      failures++; $display("FAIL ovf_clear act=%b exp=0", tx_overflow);
    end
  endtask

  task automatic test_partial();
    logic [7:0] pat, mi, ex;
    logic       b;
    pat = 8'hC0;
    rx_q.delete();
    spi_begin();
    for (int i = 7; i >= 3; i--) spi_bit(pat[i], b);
    spi_end();
    checks++;
    if (rx_q.size() != 0) begin failures++; $display("FAIL partial_no_rx count=%0d exp=0", rx_q.size()); end
    spi_begin(); spi_byte(8'hC1, mi, ex); spi_end();
    checks += 2;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hC1) begin
      failures++; $display("FAIL partial_next_rx count=%0d exp_count=1 exp=c1", rx_q.size());
    end
    if (mi !== ex) begin failures++; $display("FAIL partial_miso act=%h exp=%h", mi, ex); end
  endtask

  task automatic test_reset_mid();
    logic b;
    push_byte(8'hFF); push_byte(8'hE7);
    spi_begin();
    for (int i = 0; i < 3; i++) spi_bit(1'($urandom), b);
    spi_sclk = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (spi_miso !== 1'b1) begin failures++; $display("FAIL rmid_pre_miso act=%b exp=1", spi_miso); end
    reset = 1'b1;
    #1;
    checks += 3;
    if (tx_level !== 3'd0)  begin failures++; $display("FAIL rmid_level act=%0d exp=0", tx_level); end
    if (dataReady !== 1'b0) begin failures++; $display("FAIL rmid_dataReady act=%b exp=0", dataReady); end
    if (spi_miso !== 1'b0)  begin failures++; $display("FAIL rmid_miso act=%b exp=0", spi_miso); end
    spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    m_q.delete(); m_ovf = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (tx_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready act=%b exp=1", tx_ready); end
  endtask

  task automatic test_same_cycle_push();
    logic [7:0] mi0, ex0, mi1, ex1;
    @(negedge clock);
    spi_cs_n = 1'b0;
    m_next   = model_pop();
    // Land the push on the load cycle, SYNC_STAGES+1 clocks after the pin change.
    repeat (SYNC_STAGES + 1) @(negedge clock);
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    model_push(8'hA5);
    repeat (PH) @(negedge clock);
    spi_byte(8'($urandom) | 8'h01, mi0, ex0);
    spi_byte(8'($urandom) | 8'h01, mi1, ex1);
    spi_end();
    checks += 2;
    if (mi0 !== ex0 || mi0 !== 8'h00) begin failures++; $display("FAIL same_cycle_b0 act=%h exp=00", mi0); end
    if (mi1 !== ex1 || mi1 !== 8'hA5) begin failures++; $display("FAIL same_cycle_b1 act=%h exp=a5", mi1); end
  endtask

  task automatic test_random();
    logic [7:0] mi, ex, mo;
    logic [7:0] rx_exp[$];
    for (int it = 0; it < 8; it++) begin
      int np, nb;
      np = int'($urandom_range(0, 5));
      nb = int'($urandom_range(1, 3));
      rx_q.delete(); rx_exp.delete();
      for (int k = 0; k < np; k++) push_byte(8'($urandom));
      spi_begin();
      for (int k = 0; k < nb; k++) begin
        mo = 8'($urandom);
        rx_exp.push_back(mo);
        spi_byte(mo, mi, ex);
        checks++;
        if (mi !== ex) begin failures++; $display("FAIL rnd%0d_miso%0d act=%h exp=%h", it, k, mi, ex); end
      end
      spi_end();
      checks += 4;
      if (tx_level !== 3'(m_q.size())) begin
        failures++; $display("FAIL rnd%0d_level act=%0d exp=%0d", it, tx_level, m_q.size());
      end
      if (dataReady !== (m_q.size() != 0)) begin
        failures++; $display("FAIL rnd%0d_dataReady act=%b exp=%b", it, dataReady, m_q.size() != 0);
      end
      if (tx_overflow !== m_ovf) begin
        failures++; $display("FAIL rnd%0d_overflow act=%b exp=%b", it, tx_overflow, m_ovf);
      end
      if (rx_q != rx_exp) begin
        failures++; $display("FAIL rnd%0d_rx count=%0d exp_count=%0d", it, rx_q.size(), rx_exp.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_string();
    test_overflow();
    test_partial();
    test_reset_mid();
    test_same_cycle_push();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
